// File: rtl/io_irq_port.sv
// Device-to-CPU port: input FIFO with an IDLE/ASSERT/RELEASE interrupt handshake and a registered CPU output word.
// Define IO_IRQ_HOLDOFF_EN to enforce a minimum HOLDOFF-cycle gap between interrupt episodes.
module io_irq_port #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dev_data,
  input  logic        dev_valid,
  output logic        dev_ready,
  output logic [15:0] data_in,
  output logic        interrupt,
  input  logic        int_ack,
  input  logic [15:0] data_out,
  input  logic        out_we,
  output logic [15:0] out_word,
  output logic        out_valid,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   out_word_q;
  logic          out_valid_q, overflow_q;
  logic          full, empty, push, pop, hold_done;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = (state_q == S_ASSERT) && int_ack && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO may still accept a push.
  assign push  = dev_valid && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (dev_valid && !push) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= dev_data;
  end

`ifdef IO_IRQ_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF + 1);
  logic [HW-1:0] hold_q;

  // Counts RELEASE cycles; interrupt has been low for hold_q+1 cycles.
  assign hold_done = (int'(hold_q) + 1) >= HOLDOFF;

  always_ff @(posedge clk) begin
    if (reset)                       hold_q <= '0;
    else if (state_q != S_RELEASE)   hold_q <= '0;
    else if (!hold_done)             hold_q <= hold_q + 1'b1;
  end
`else
  // HOLDOFF only matters when the holdoff counter is built.
  assign hold_done = (HOLDOFF >= 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!empty || push)        state_d = S_ASSERT;
      S_ASSERT:  if (int_ack)               state_d = S_RELEASE;
      S_RELEASE: if (!int_ack && hold_done) state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_we;
      if (out_we) out_word_q <= data_out;
    end
  end

  assign dev_ready = !full;
  assign data_in   = empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign interrupt = (state_q == S_ASSERT);
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_io_irq_port.sv
// Bench for io_irq_port: queue-based reference model checked every cycle, plus directed literal checks.
module tb_io_irq_port;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, dev_valid, int_ack, out_we;
  logic [15:0] dev_data, data_out;
  logic        dev_ready, interrupt, out_valid, overflow;
  logic [15:0] data_in, out_word;

  always #5 clk = ~clk;

  io_irq_port #(.DEPTH(DEPTH), .HOLDOFF(4)) dut (
    .clk(clk), .reset(reset), .dev_data(dev_data), .dev_valid(dev_valid),
    .dev_ready(dev_ready), .data_in(data_in), .interrupt(interrupt),
    .int_ack(int_ack), .data_out(data_out), .out_we(out_we),
    .out_word(out_word), .out_valid(out_valid), .overflow(overflow)
  );

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: a word queue plus "interrupt raised" / "waiting for ack release" flags.
  logic [15:0] mq[$];
  bit          m_irq, m_rel, m_ovf, m_ov;
  logic [15:0] m_ow;

  always @(posedge clk) begin
    bit full, pop, pushok;
    if (reset) begin
      mq.delete();
      m_irq = 0; m_rel = 0; m_ovf = 0; m_ov = 0; m_ow = 16'h0;
    end else begin
      full   = (mq.size() == DEPTH);
      pop    = m_irq && int_ack && (mq.size() > 0);
      pushok = dev_valid && (!full || pop);
      if (dev_valid && !pushok) m_ovf = 1;
      m_ov = out_we;
      if (out_we) m_ow = data_out;
      if (m_irq) begin
        if (int_ack) begin m_irq = 0; m_rel = 1; end
      end else if (m_rel) begin
        if (!int_ack) m_rel = 0;
      end else if (mq.size() > 0 || pushok) begin
        m_irq = 1;
      end
      if (pop) void'(mq.pop_front());
      if (pushok) mq.push_back(dev_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_dev_ready", 16'(dev_ready), 16'(mq.size() < DEPTH));
      chk("m_data_in",   data_in, (mq.size() > 0) ? mq[0] : 16'h0000);
      chk("m_interrupt", 16'(interrupt), 16'(m_irq));
      chk("m_overflow",  16'(overflow), 16'(m_ovf));
      chk("m_out_valid", 16'(out_valid), 16'(m_ov));
      chk("m_out_word",  out_word, m_ow);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input string nm);
    int n = 0;
    while (!interrupt && n < 20) begin step(); n++; end
    chk(nm, 16'(interrupt), 16'h1);
  endtask

  task automatic push_word(input logic [15:0] w);
    dev_valid = 1'b1; dev_data = w;
    step();
    dev_valid = 1'b0;
  endtask

  task automatic ack_once();
    int_ack = 1'b1; step();
    int_ack = 1'b0; step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp4 [4];
    reset = 1'b1; dev_valid = 1'b1; dev_data = 16'hFFFF;
    int_ack = 1'b1; out_we = 1'b1; data_out = 16'hBEEF;
    step(); step();
    reset = 1'b0; dev_valid = 1'b0; int_ack = 1'b0; out_we = 1'b0;
    chk("rst_dev_ready", 16'(dev_ready), 16'h1);
    chk("rst_data_in",   data_in, 16'h0000);
    chk("rst_interrupt", 16'(interrupt), 16'h0);
    chk("rst_overflow",  16'(overflow), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_word",  out_word, 16'h0000);
    chk_en = 1'b1;

    // Single word
    push_word(16'hA5A5);
    chk("single_irq",  16'(interrupt), 16'h1);
    chk("single_data", data_in, 16'hA5A5);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("single_irq_drop", 16'(interrupt), 16'h0);
    chk("single_empty",    data_in, 16'h0000);
    step(); step();

    // Fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    chk("full_ready", 16'(dev_ready), 16'h0);
    push_word(16'h0005);
    chk("ovf_flag",  16'(overflow), 16'h1);
    chk("ovf_head",  data_in, 16'h0001);
    for (int i = 1; i <= 4; i++) begin
      wait_irq("drain_irq");
      chk("drain_order", data_in, 16'(i));
      ack_once();
    end
    step();
    chk("drain_empty", data_in, 16'h0000);
    chk("ovf_sticky",  16'(overflow), 16'h1);

    // Reset mid-episode and mid-push
    push_word(16'h00AA);
    chk("mid_irq", 16'(interrupt), 16'h1);
    reset = 1'b1; dev_valid = 1'b1; dev_data = 16'h00BB; int_ack = 1'b1; out_we = 1'b1;
    step();
    reset = 1'b0; dev_valid = 1'b0; int_ack = 1'b0; out_we = 1'b0;
    chk("mid_rst_irq",   16'(interrupt), 16'h0);
    chk("mid_rst_data",  data_in, 16'h0000);
    chk("mid_rst_ovf",   16'(overflow), 16'h0);
    chk("mid_rst_ready", 16'(dev_ready), 16'h1);
    chk("mid_rst_ov",    16'(out_valid), 16'h0);

    // Held ack pops exactly once
    push_word(16'h0011);
    push_word(16'h0022);
    int_ack = 1'b1;
    repeat (5) step();
    chk("held_one_pop", data_in, 16'h0022);
    chk("held_irq_low", 16'(interrupt), 16'h0);
    int_ack = 1'b0;
    step(); step();
    chk("held_reassert", 16'(interrupt), 16'h1);
    ack_once();
    step();

    // Simultaneous push and pop while full
    for (int i = 1; i <= 4; i++) push_word(16'h0100 + 16'(i));
    chk("sim_full", 16'(dev_ready), 16'h0);
    int_ack = 1'b1; dev_valid = 1'b1; dev_data = 16'h0009;
    step();
    int_ack = 1'b0; dev_valid = 1'b0;
    chk("sim_no_ovf", 16'(overflow), 16'h0);
    chk("sim_count4", 16'(dev_ready), 16'h0);
    chk("sim_head",   data_in, 16'h0102);
    exp4[0] = 16'h0102; exp4[1] = 16'h0103; exp4[2] = 16'h0104; exp4[3] = 16'h0009;
    for (int i = 0; i < 4; i++) begin
      wait_irq("sim_irq");
      chk("sim_order", data_in, exp4[i]);
      ack_once();
    end

    // CPU output writes back-to-back
    out_we = 1'b1; data_out = 16'h1234;
    step();
    chk("out_v1", 16'(out_valid), 16'h1);
    chk("out_w1", out_word, 16'h1234);
    data_out = 16'h5678;
    step();
    out_we = 1'b0;
    chk("out_v2", 16'(out_valid), 16'h1);
    chk("out_w2", out_word, 16'h5678);
    step();
    chk("out_v3", 16'(out_valid), 16'h0);
    chk("out_w3", out_word, 16'h5678);

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
